// File: rtl/m_capture.sv
// rtl/m_capture.sv - triggered capture buffer: pre/post-trigger sample window with in-order readout
module m_capture #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 256,
  parameter int PRE   = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in,
  input  logic             positive,
  input  logic             negative,
  input  logic [1:0]       edge_sel,
  input  logic             arm,
  input  logic             abort,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  output logic             busy,
  output logic             done,
  output logic             trig_pol
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int CNT_W  = ADDR_W + 1;

  localparam logic [CNT_W-1:0]  PRE_LAST  = CNT_W'(PRE - 1);
  localparam logic [CNT_W-1:0]  POST_LAST = CNT_W'(DEPTH - PRE - 2);
  localparam logic [CNT_W-1:0]  READ_LAST = CNT_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] PRE_OFF   = ADDR_W'(PRE);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_WAIT,
    S_POST,
    S_READ
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W-1:0] trig_addr_q, trig_addr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [WIDTH-1:0]  rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic              trig_pol_q, trig_pol_d;
  logic              wr_en;
  logic              trig;

  logic [WIDTH-1:0]  mem_q [DEPTH];

  assign trig = (positive & edge_sel[0]) | (negative & edge_sel[1]);

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    trig_addr_d = trig_addr_q;
    count_d     = count_q;
    rd_data_d   = rd_data_q;
    rd_valid_d  = 1'b0;
    trig_pol_d  = trig_pol_q;
    wr_en       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (arm) begin
          wr_ptr_d = '0;
          count_d  = '0;
          state_d  = S_FILL;
        end
      end
      S_FILL: begin
        wr_en    = 1'b1;
        wr_ptr_d = wr_ptr_q + ADDR_W'(1);
        count_d  = count_q + CNT_W'(1);
        if (count_q == PRE_LAST) state_d = S_WAIT;
      end
      S_WAIT: begin
        wr_en    = 1'b1;
        wr_ptr_d = wr_ptr_q + ADDR_W'(1);
        if (trig) begin
          trig_addr_d = wr_ptr_q;
          trig_pol_d  = positive & edge_sel[0];
          count_d     = '0;
          state_d     = S_POST;
        end
      end
      S_POST: begin
        wr_en    = 1'b1;
        wr_ptr_d = wr_ptr_q + ADDR_W'(1);
        count_d  = count_q + CNT_W'(1);
        if (count_q == POST_LAST) begin
          // Oldest retained sample sits PRE slots before the trigger.
          rd_ptr_d = trig_addr_q - PRE_OFF;
          count_d  = '0;
          state_d  = S_READ;
        end
      end
      S_READ: begin
        if (rd_en) begin
          rd_data_d  = mem_q[rd_ptr_q];
          rd_valid_d = 1'b1;
          rd_ptr_d   = rd_ptr_q + ADDR_W'(1);
          count_d    = count_q + CNT_W'(1);
          if (count_q == READ_LAST) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (abort) begin
      state_d    = S_IDLE;
      rd_valid_d = 1'b0;
      rd_data_d  = rd_data_q;
      trig_pol_d = trig_pol_q;
      wr_en      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      trig_addr_q <= '0;
      count_q     <= '0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      trig_pol_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      trig_addr_q <= trig_addr_d;
      count_q     <= count_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      trig_pol_q  <= trig_pol_d;
    end
  end

  // Sample storage keeps its contents through reset.
  always_ff @(posedge clk) begin
    if (wr_en && rst_n) mem_q[wr_ptr_q] <= in;
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign trig_pol = trig_pol_q;
  assign busy     = (state_q == S_FILL) || (state_q == S_WAIT) || (state_q == S_POST);
  assign done     = (state_q == S_READ);

endmodule

// File: tb/tb_m_capture.sv
// tb/tb_m_capture.sv - randomized and directed bench for m_capture against a sample-history model
module tb_m_capture;
  localparam int WIDTH = 8;
  localparam int DEPTH = 16;
  localparam int PRE   = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [WIDTH-1:0] in_s;
  logic             positive, negative;
  logic [1:0]       edge_sel;
  logic             arm, abort, rd_en;
  logic [WIDTH-1:0] rd_data;
  logic             rd_valid, busy, done, trig_pol;

  always #5 clk = ~clk;

  m_capture #(.WIDTH(WIDTH), .DEPTH(DEPTH), .PRE(PRE)) dut (
    .clk(clk), .rst_n(rst_n), .in(in_s), .positive(positive), .negative(negative),
    .edge_sel(edge_sel), .arm(arm), .abort(abort), .rd_en(rd_en),
    .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy), .done(done), .trig_pol(trig_pol)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Model: remembers every sample written since arm; the capture window is
  // simply hist[t-PRE .. t+DEPTH-PRE-1] where t is the index of the trigger sample.
  logic [7:0] hist[$];
  logic [7:0] m_buf[DEPTH];
  int         m_mode = 0;   // 0 idle, 1 capturing, 2 reading
  int         m_t, m_r, m_n;
  bit         m_live = 0;
  logic       e_valid = 0, e_pol = 0;
  logic [7:0] e_data = 0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_mode = 0; e_valid = 0; e_data = 0; e_pol = 0; m_live = 1;
    end else begin
      e_valid = 0;
      if (abort) m_mode = 0;
      else case (m_mode)
        0: if (arm) begin m_mode = 1; hist.delete(); m_t = -1; end
        1: begin
          hist.push_back(in_s);
          m_n = hist.size() - 1;
          if (m_t >= 0 && m_n == m_t + DEPTH - PRE - 1) begin
            for (int k = 0; k < DEPTH; k++) m_buf[k] = hist[m_t - PRE + k];
            m_mode = 2; m_r = 0;
          end else if (m_t < 0 && m_n >= PRE &&
                       ((positive & edge_sel[0]) | (negative & edge_sel[1]))) begin
            m_t = m_n;
            e_pol = positive & edge_sel[0];
          end
        end
        2: if (rd_en) begin
          e_valid = 1; e_data = m_buf[m_r]; m_r++;
          if (m_r == DEPTH) m_mode = 0;
        end
        default: m_mode = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      chk("cyc_busy", busy, m_mode == 1);
      chk("cyc_done", done, m_mode == 2);
      chk("cyc_rd_valid", rd_valid, e_valid);
      chk("cyc_rd_data", rd_data, e_data);
      chk("cyc_trig_pol", trig_pol, e_pol);
    end
  end

  logic [7:0] got[$];

  task automatic step();
    @(negedge clk); #1;
  endtask

  task automatic capture(input logic [1:0] es, input int p0, input int p1, input int p2,
                         input int n0, input int limit, input bit rnd,
                         output bit ok, output logic busy100);
    edge_sel = es; arm = 1; step(); arm = 0;
    ok = 0; busy100 = 0;
    for (int i = 0; i < limit; i++) begin
      in_s     = rnd ? 8'($urandom) : i[7:0];
      positive = rnd ? ($urandom_range(0, 7) == 0) : (i == p0 || i == p1 || i == p2);
      negative = rnd ? ($urandom_range(0, 7) == 0) : (i == n0);
      arm      = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
      step();
      if (i == 100) busy100 = busy;
      if (done) begin ok = 1; break; end
    end
    positive = 0; negative = 0; arm = 0;
  endtask

  task automatic readout(input int cyc, input bit gaps, output int nvalid);
    got.delete(); nvalid = 0;
    for (int i = 0; i < cyc; i++) begin
      rd_en = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      step();
      if (rd_valid) begin got.push_back(rd_data); nvalid++; end
    end
    rd_en = 0;
  endtask

  task automatic check_ramp(input string name, input int first);
    chk({name, "_count"}, got.size(), DEPTH);
    for (int k = 0; k < DEPTH && k < got.size(); k++)
      chk({name, "_data"}, got[k], (first + k) & 8'hff);
  endtask

  bit   ok;
  logic b100;
  int   nv;

  initial begin
    rst_n = 0; in_s = 0; positive = 0; negative = 0; edge_sel = 0;
    arm = 0; abort = 0; rd_en = 0;
    repeat (3) step();
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_rd_valid", rd_valid, 0);
    chk("reset_rd_data", rd_data, 0);
    chk("reset_trig_pol", trig_pol, 0);
    rst_n = 1; step();

    capture(2'b01, 20, -1, -1, -1, 100, 0, ok, b100);
    chk("ramp20_ready", ok, 1);
    readout(16, 0, nv);
    check_ramp("ramp20", 16);
    chk("ramp20_pol", trig_pol, 1);
    chk("ramp20_idle", done, 0);

    capture(2'b01, 1, 2, 9, -1, 100, 0, ok, b100);
    chk("fill_ignore_ready", ok, 1);
    readout(16, 0, nv);
    check_ramp("fill_ignore", 5);

    capture(2'b10, 20, 50, 150, 296, 400, 0, ok, b100);
    chk("neg_ready", ok, 1);
    chk("neg_busy100", b100, 1);
    readout(16, 0, nv);
    check_ramp("neg", 36);
    chk("neg_pol", trig_pol, 0);

    capture(2'b11, 10, -1, -1, 10, 100, 0, ok, b100);
    chk("both_ready", ok, 1);
    chk("both_pol", trig_pol, 1);
    readout(20, 0, nv);
    chk("both_pulses", nv, 16);
    check_ramp("both", 6);
    chk("both_idle", done, 0);

    capture(2'b01, 10, -1, -1, -1, 14, 0, ok, b100);
    chk("abort_in_post", busy, 1);
    abort = 1; step(); abort = 0;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    readout(5, 0, nv);
    chk("abort_no_read", nv, 0);

    capture(2'b01, 10, -1, -1, -1, 100, 0, ok, b100);
    chk("rst_ready", ok, 1);
    readout(5, 0, nv);
    rst_n = 0; step();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_trig_pol", trig_pol, 0);
    rst_n = 1; step();
    readout(4, 0, nv);
    chk("rst_no_read", nv, 0);

    capture(2'b01, 18, -1, -1, -1, 100, 0, ok, b100);
    chk("wrap_ready", ok, 1);
    readout(16, 0, nv);
    check_ramp("wrap", 14);

    repeat (12) begin
      capture(2'($urandom_range(0, 3)), -1, -1, -1, -1, 200, 1, ok, b100);
      if (ok) readout(40, 1, nv);
      if (busy || done) begin abort = 1; step(); abort = 0; end
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
